// File: rtl/cube_calc_pkg.sv
// Shared definitions for the cube unit and its shift-add multiplier.
// Holds the top FSM encoding, width helpers and latency constant.
package cube_calc_pkg;

  localparam int W_DEF = 8;
  localparam int PW = 3 * W_DEF;
  localparam int SQW = 2 * W_DEF;
  localparam int CUBE_LATENCY = 2 * W_DEF + 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SQ_ARM  = 3'd1,
    ST_SQ_WAIT = 3'd2,
    ST_CB_ARM  = 3'd3,
    ST_CB_WAIT = 3'd4
  } state_t;

  function automatic int pw_of(input int w);
    return 3 * w;
  endfunction

  function automatic int sqw_of(input int w);
    return 2 * w;
  endfunction

  function automatic int lat_of(input int w);
    return 2 * w + 4;
  endfunction

endpackage

// File: rtl/cube_calc_if.sv
// Start/busy/done handshake bundle for cube_calc.
// master: requester (start, x_in); slave: cube unit (y_out, busy_o, done_o).
interface cube_calc_if #(
  parameter int W = 8
);
  logic             start;
  logic [W-1:0]     x_in;
  logic [3*W-1:0]   y_out;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start, x_in,
    input  y_out, busy_o, done_o
  );

  modport slave (
    input  start, x_in,
    output y_out, busy_o, done_o
  );
endinterface

// File: rtl/cube_calc_shift_add_mul.sv
// Sequential unsigned shift-add multiplier, one bit of b per cycle.
// Ports: start/a/b in, busy high BW cycles, p holds last product.
module shift_add_mul #(
  parameter int AW = 16,
  parameter int BW = 8,
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          busy,
  output logic [PW-1:0] p
);

  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  logic [PW-1:0] a_r;
  logic [BW-1:0] b_r;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [CW-1:0] cnt;

  always_comb begin
    acc_next = acc + (b_r[0] ? a_r : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      p    <= '0;
    end else if (!busy) begin
      if (start) begin
        a_r  <= PW'(a);
        b_r  <= b;
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end
    end else begin
      acc <= acc_next;
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(BW - 1)) begin
        p    <= acc_next;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cube_calc.sv
// Sequential cube y = x^3 using one shared multiplier twice.
// Ports: clk, rst, bus (slave: start, x_in -> y_out, busy_o, done_o).
module cube_calc
  import cube_calc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  cube_calc_if.slave   bus
);

  localparam int PWL  = pw_of(W);
  localparam int SQWL = sqw_of(W);

  state_t           state;
  logic [W-1:0]     x_r;
  logic [SQWL-1:0]  mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_start;
  logic             mul_busy;
  logic [PWL-1:0]   mul_p;
  logic [PWL-1:0]   y_r;
  logic             busy_r;
  logic             done_r;

  assign bus.y_out  = y_r;
  assign bus.busy_o = busy_r;
  assign bus.done_o = done_r;

  shift_add_mul #(
    .AW (SQWL),
    .BW (W),
    .PW (PWL)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .busy  (mul_busy),
    .p     (mul_p)
  );

  // ARM states give the multiplier one edge to raise busy
  // before the WAIT states start polling it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x_r       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      y_r       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            x_r       <= bus.x_in;
            mul_a     <= SQWL'(bus.x_in);
            mul_b     <= bus.x_in;
            mul_start <= 1'b1;
            busy_r    <= 1'b1;
            state     <= ST_SQ_ARM;
          end
        end
        ST_SQ_ARM: begin
          mul_start <= 1'b0;
          state     <= ST_SQ_WAIT;
        end
        ST_SQ_WAIT: begin
          if (!mul_busy) begin
            mul_a     <= mul_p[SQWL-1:0];
            mul_b     <= x_r;
            mul_start <= 1'b1;
            state     <= ST_CB_ARM;
          end
        end
        ST_CB_ARM: begin
          mul_start <= 1'b0;
          state     <= ST_CB_WAIT;
        end
        ST_CB_WAIT: begin
          if (!mul_busy) begin
            y_r    <= mul_p;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          mul_start <= 1'b0;
          busy_r    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cube_calc.sv
// Scoreboard bench for cube_calc (W=8).
// Expected cubes are queued at start and checked on done_o.
module tb_cube_calc;
  import cube_calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cube_calc_if #(.W(8)) bus ();

  cube_calc #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_ops  = 0;
  int busy_run = 0;
  logic prev_done = 1'b0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int icbrt(input logic [7:0] v);
    int r = 0;
    for (int k = 0; k <= 6; k++)
      if (k * k * k <= int'(v)) r = k;
    return r;
  endfunction

  // Monitor: busy run length, done pulse width, result scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.busy_o) busy_run++;
      if (prev_done) chk("done_width", bus.done_o, 0);
      if (bus.done_o) begin
        n_done++;
        chk("done_busy_low", bus.busy_o, 0);
        chk("busy_cycles", busy_run, CUBE_LATENCY);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("y_out", bus.y_out, exp_q.pop_front());
        end
      end
    end
    prev_done = bus.done_o;
  end

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("timeout", 0, 1);
  endtask

  task automatic do_op(input logic [7:0] x);
    logic [23:0] e;
    e = 24'(x) * 24'(x) * 24'(x);
    bus.start = 1'b1;
    bus.x_in  = x;
    exp_q.push_back(e);
    n_ops++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_in  = 8'($urandom);
    wait_done();
  endtask

  initial begin
    bus.start = 1'b1;
    bus.x_in  = 8'd7;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_y", bus.y_out, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", bus.busy_o, 0);
    end

    for (int x = 0; x <= 10; x++) do_op(8'(x));

    do_op(8'd255);
    chk("y_max", bus.y_out, 24'hFD02FF);
    chk("square_reg", dut.mul_a, 65025);

    // Restart attempts mid-operation must be ignored.
    bus.start = 1'b1;
    bus.x_in  = 8'd5;
    exp_q.push_back(24'd125);
    n_ops++;
    begin
      logic seen = 1'b0;
      for (int c = 1; c < 60; c++) begin
        @(negedge clk);
        if (c == 2 || c == 14) begin
          bus.start = 1'b1;
          bus.x_in  = 8'd9;
        end else begin
          bus.start = 1'b0;
          bus.x_in  = 8'd9;
        end
        if (bus.done_o) begin
          seen = 1'b1;
          break;
        end
      end
      bus.start = 1'b0;
      if (!seen) chk("timeout_ign", 0, 1);
    end
    repeat (3) @(negedge clk);
    chk("ign_idle", bus.busy_o, 0);

    // Reset during an operation drops it.
    bus.start = 1'b1;
    bus.x_in  = 8'd10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_y", bus.y_out, 0);
    @(negedge clk);
    chk("post_rst_busy", bus.busy_o, 0);
    do_op(8'd4);

    // Round trip, back to back.
    for (int y = 0; y <= 6; y++) begin
      do_op(8'(y));
      chk("round_trip", icbrt(bus.y_out[7:0]), y);
    end

    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_ops);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
